// File: rtl/usb_crc_serializer.sv
// USB transmit serializer: payload LSB-first, then complemented CRC5/CRC16 MSB-first.
// Define USB_CRC_SELFCHECK_EN to build in a receiver-side residual check (crc_err).
module usb_crc_serializer #(
    parameter int MAX_BITS = 64,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_BITS-1:0] in_data,
    input  logic [LEN_W-1:0]    in_len,
    input  logic                in_crc16,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic                out_last,
`ifdef USB_CRC_SELFCHECK_EN
    output logic                crc_err,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    // CRC5 lives in the low five bits; the upper bits stay zero.
    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic        sel,
        input logic        b
    );
        logic fb;
        if (sel) begin
            fb = c[15] ^ b;
            return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        fb = c[4] ^ b;
        return {11'd0, c[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
    endfunction

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] data_q, data_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                sel_q, sel_d;
    logic [15:0]         crc_q, crc_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_bit_q, out_bit_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;

    logic                beat;
    logic [LEN_W-1:0]    len_clamp;
    logic [MAX_BITS-1:0] shifted;

    assign beat      = out_valid_q & out_ready;
    assign len_clamp = (in_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : in_len;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        sel_d   = sel_q;
        crc_d   = crc_q;
        idx_d   = idx_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_d = in_data;
                        sel_d  = in_crc16;
                        len_d  = len_clamp;
                        crc_d  = in_crc16 ? 16'hFFFF : 16'h001F;
                        idx_d  = '0;
                        if (len_clamp != '0) begin
                            state_d = DATA;
                        end else begin
                            state_d = CRC;
                            idx_d   = in_crc16 ? LEN_W'(15) : LEN_W'(4);
                        end
                    end
                end
                DATA: begin
                    if (beat) begin
                        crc_d = crc_step(crc_q, sel_q, out_bit_q);
                        if (idx_q + LEN_W'(1) == len_q) begin
                            state_d = CRC;
                            idx_d   = sel_q ? LEN_W'(15) : LEN_W'(4);
                        end else begin
                            idx_d = idx_q + LEN_W'(1);
                        end
                    end
                end
                CRC: begin
                    if (beat) begin
                        if (idx_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q - LEN_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state view so they track state_q.
    always_comb begin
        shifted     = data_d >> idx_d;
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d != IDLE);
        out_bit_d   = 1'b0;
        out_last_d  = 1'b0;
        if (state_d == DATA) begin
            out_bit_d = shifted[0];
        end else if (state_d == CRC) begin
            out_bit_d  = ~crc_d[idx_d[3:0]];
            out_last_d = (idx_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            data_q      <= '0;
            len_q       <= '0;
            sel_q       <= 1'b0;
            crc_q       <= 16'hFFFF;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            len_q       <= len_d;
            sel_q       <= sel_d;
            crc_q       <= crc_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

`ifdef USB_CRC_SELFCHECK_EN
    logic [15:0] chk_q, chk_d;
    logic        crc_err_q, crc_err_d;

    // Receiver view: every emitted bit, CRC included, must leave the fixed residual.
    always_comb begin
        chk_d     = chk_q;
        crc_err_d = 1'b0;
        if (!abort) begin
            if (state_q == IDLE && in_valid) begin
                chk_d = in_crc16 ? 16'hFFFF : 16'h001F;
            end else if (beat) begin
                chk_d = crc_step(chk_q, sel_q, out_bit_q);
                if (out_last_q) begin
                    crc_err_d = chk_d != (sel_q ? 16'h800D : 16'h000C);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            chk_q     <= 16'hFFFF;
            crc_err_q <= 1'b0;
        end else begin
            chk_q     <= chk_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_err = crc_err_q;
`endif

endmodule

// File: tb/tb_usb_crc_serializer.sv
// Self-checking bench for usb_crc_serializer: directed and random packets
// against a polynomial-division reference model.
module tb_usb_crc_serializer;

    logic        clk;
    logic        rst_b;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [6:0]  in_len;
    logic        in_crc16;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic        out_bit;
    logic        out_last;
    logic        busy;
`ifdef USB_CRC_SELFCHECK_EN
    logic        crc_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    usb_crc_serializer #(.MAX_BITS(64)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_crc16  (in_crc16),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
`ifdef USB_CRC_SELFCHECK_EN
        .crc_err   (crc_err),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Remainder of (S(x)*x^W + ones(x)*x^N) mod G, first bit of q is highest degree.
    function automatic logic [15:0] poly_rem(input bit q[$], input bit sel);
        logic [127:0] v;
        logic [127:0] g;
        int w;
        int n;
        w = sel ? 16 : 5;
        g = sel ? 128'h18005 : 128'h25;
        n = q.size();
        v = '0;
        for (int i = 0; i < n; i++) v[n - 1 - i + w] = q[i];
        for (int j = 0; j < w; j++) v[n + j] = ~v[n + j];
        for (int k = n + w - 1; k >= w; k--) begin
            if (v[k]) v = v ^ (g << (k - w));
        end
        return sel ? v[15:0] : {11'd0, v[4:0]};
    endfunction

    task automatic run_pkt(input logic [63:0] d, input int len_in, input bit sel,
                           input bit stall, input int abort_at);
        bit exp[$];
        bit got[$];
        int n;
        int w;
        int cyc;
        int k;
        logic [15:0] c;
        logic prev_bit;
        bit prev_stall;
        n = (len_in > 64) ? 64 : len_in;
        w = sel ? 16 : 5;
        for (int i = 0; i < n; i++) exp.push_back(d[i]);
        c = poly_rem(exp, sel);
        for (int j = w - 1; j >= 0; j--) exp.push_back(~c[j]);

        cyc = 0;
        while (!in_ready && cyc < 200) begin
            step;
            cyc++;
        end
        chk("in_ready_idle", in_ready, 1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_len    = 7'(len_in);
        in_crc16  = sel;
        step;
        in_valid  = 1'b0;
        in_data   = {$urandom, $urandom};
        in_len    = 7'($urandom_range(0, 127));
        in_crc16  = 1'($urandom_range(0, 1));
        chk("first_valid", out_valid, 1'b1);
        chk("busy_high", busy, 1'b1);
        chk("in_ready_low", in_ready, 1'b0);

        k = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_bit = 1'b0;
        while (k < exp.size() && cyc < 2000) begin
            if (prev_stall) chk("stall_hold", out_bit, prev_bit);
            if (abort_at == k) begin
                abort = 1'b1;
                in_valid = 1'b1;
                step;
                abort = 1'b0;
                in_valid = 1'b0;
                chk("abort_valid", out_valid, 1'b0);
                chk("abort_ready", in_ready, 1'b1);
                chk("abort_busy", busy, 1'b0);
                return;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("valid_mid", out_valid, 1'b1);
            chk("ready_mid", in_ready, 1'b0);
`ifdef USB_CRC_SELFCHECK_EN
            chk("crc_err_mid", crc_err, 1'b0);
`endif
            if (out_ready) begin
                chk("bit", out_bit, exp[k]);
                chk("last", out_last, k == exp.size() - 1);
                got.push_back(out_bit);
                k++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_bit = out_bit;
            end
            step;
            cyc++;
        end
        out_ready = 1'b1;
        chk("beats_done", k == exp.size(), 1'b1);
        if (!stall) chk("pkt_cycles", cyc == n + w, 1'b1);
        chk("end_valid", out_valid, 1'b0);
        chk("end_ready", in_ready, 1'b1);
        chk("end_busy", busy, 1'b0);
`ifdef USB_CRC_SELFCHECK_EN
        chk("crc_err_end", crc_err, 1'b0);
`endif
        chk16("residual", poly_rem(got, sel), sel ? 16'h800D : 16'h000C);
    endtask

    initial begin
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        in_crc16  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
`ifdef USB_CRC_SELFCHECK_EN
        chk("rst_crc_err", crc_err, 1'b0);
`endif
        rst_b = 1'b1;
        step;

        run_pkt(64'h0, 11, 1'b0, 1'b0, -1);
        run_pkt(64'h715, 11, 1'b0, 1'b0, -1);
        run_pkt(64'h0, 0, 1'b1, 1'b0, -1);
        run_pkt(64'h0706050403020100, 64, 1'b1, 1'b0, -1);
        run_pkt(64'h0706050403020100, 64, 1'b1, 1'b1, -1);
        run_pkt(64'h0706050403020100, 100, 1'b1, 1'b0, -1);

        run_pkt({$urandom, $urandom}, 64, 1'b1, 1'b0, 20);
        run_pkt(64'h0, 11, 1'b0, 1'b0, -1);

        // Reset pulse while the CRC field is being sent.
        in_valid = 1'b1;
        in_data  = 64'h3A5;
        in_len   = 7'd11;
        in_crc16 = 1'b0;
        step;
        in_valid = 1'b0;
        repeat (13) step;
        chk("pre_rst_busy", busy, 1'b1);
        rst_b = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_bit", out_bit, 1'b0);
        chk("arst_out_last", out_last, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
`ifdef USB_CRC_SELFCHECK_EN
        chk("arst_crc_err", crc_err, 1'b0);
`endif
        repeat (2) step;
        rst_b = 1'b1;
        step;
        chk("post_rst_valid", out_valid, 1'b0);
        run_pkt(64'h0, 11, 1'b0, 1'b0, -1);

        for (int p = 0; p < 12; p++) begin
            run_pkt({$urandom, $urandom}, int'($urandom_range(0, 80)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_crc_serializer.md
# usb_crc_serializer

Parametrised USB transmit-path serializer that accepts a parallel packet body (token address/endpoint field or data payload), shifts it out LSB-first one bit per accepted cycle while computing CRC5 or CRC16 on the fly, then appends the complemented CRC MSB-first. It sits between the packet assembler and the bit-stuffing/NRZI stage. It replaces the fixed 11-bit, CRC5-only token encoder with per-packet CRC selection, variable length and a stallable valid/ready output.

## Interface
- MAX_BITS, 64, maximum payload length in bits (≥11); LEN_W = $clog2(MAX_BITS+1) is derived
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- in_valid  in  1  packet body offered
- in_ready  out  1  block can accept a packet body (IDLE only)
- in_data  in  MAX_BITS  payload; bit 0 is transmitted first
- in_len  in  LEN_W  payload length in bits, 0..MAX_BITS
- in_crc16  in  1  1 = CRC16 (data packet), 0 = CRC5 (token)
- abort  in  1  synchronous flush to IDLE
- out_valid  out  1  out_bit is valid
- out_ready  in  1  downstream (bit stuffer) accepts out_bit this cycle
- out_bit  out  1  serial bit
- out_last  out  1  out_bit is the final CRC bit
- busy  out  1  state ≠ IDLE
- crc_err  out  1  self-check failure pulse (present only with USB_CRC_SELFCHECK_EN)

## Operation
- States: IDLE, DATA, CRC.
- IDLE: in_ready=1. On in_valid: latch in_data, sel=in_crc16, len=min(in_len, MAX_BITS), crc=all ones (5 or 16 bits), idx=0. Go to DATA if len>0, else CRC with idx=W-1.
- DATA: out_bit=data[idx]. On beat (out_valid&out_ready): update CRC with that bit, idx++. After beat on idx=len-1, go to CRC with idx=W-1 (W=5 or 16).
- CRC update per payload bit b: fb=crc[W-1]^b; crc={crc[W-2:0],1'b0} ^ (fb ? POLY : 0). POLY=5'b00101 (CRC5) or 16'h8005 (CRC16).
- CRC: out_bit=~crc[idx]. The CRC register is frozen. On beat idx--. out_last=1 when idx==0. On beat with idx==0, go to IDLE.
- abort (any state, highest priority after reset): next state IDLE, out_valid=0. The latched body is discarded. An in_valid in the same cycle is not accepted.
- out_bit is held stable while out_valid=1 and out_ready=0. The stall length is unbounded.
- in_len > MAX_BITS is clamped to MAX_BITS.

## Timing
- Reset values: in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0, crc_err=0, state IDLE. All internal registers cleared; CRC register set to all ones.
- Accept at cycle t. First out_valid at t+1 (registered state).
- With out_ready held at 1, a packet occupies exactly len+W output cycles, followed by one IDLE cycle. Throughput is one packet per len+W+1 cycles.
- in_ready is low from t+1 until the cycle after the final beat.
- out_valid=1 in DATA and CRC only. out_valid is never deasserted mid-packet except by abort or reset.
- rst_b asserted mid-packet: all outputs return to their reset values immediately (asynchronous). No partial CRC is emitted after release.

## Configuration
- USB_CRC_SELFCHECK_EN defined: compile in a receiver-side CRC register of the selected width. It is initialised to all ones at accept and updated with every emitted bit, payload and CRC alike, in transmit order using the same LFSR.
- When the out_last beat completes, the residual must equal 5'b01100 (CRC5) or 16'h800D (CRC16). On mismatch, crc_err pulses high for one cycle, registered, in the cycle after the final beat.
- USB_CRC_SELFCHECK_EN undefined: no checker logic and no crc_err port.

## Test plan
- Token, addr=0x00, endp=0x0 (in_len=11, in_crc16=0, out_ready=1) -> 11 zero bits, then CRC bits 0,0,0,1,0 (CRC5=5'h02 sent MSB-first), out_last on cycle 16, in_ready back high on cycle 17.
- Token, addr=0x15, endp=0xE (in_data=11'h715) -> CRC5 field 5'h17 sent as 1,0,1,1,1.
- Zero-length DATA0 (in_len=0, in_crc16=1) -> exactly 16 CRC bits, all 0 (CRC16=16'h0000), out_last on bit 16.
- 64-bit payload 0x0706050403020100, CRC16, with out_ready toggling pseudo-randomly -> bit sequence identical to the out_ready=1 run; out_bit stable during stalls; crc_err never asserted.
- abort asserted at data bit 20 of a 64-bit packet -> out_valid=0 next cycle, in_ready=1. The next packet's CRC matches a fresh-reset run.
- rst_b pulsed low during the CRC phase -> outputs immediately at reset values. A following token addr=0x00/endp=0x0 yields CRC5 5'h02.
